// File: rtl/fxp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mult_pipe
// Description : Two-stage pipelined signed Q-format multiplier. LANES lanes
//               share one valid/ready handshake. Each beat carries its own
//               rounding mode. Results saturate, with per-lane and sticky
//               overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mult_pipe #(
    parameter int QLEN      = 16,
    parameter int FRAC_SIZE = 12,
    parameter int LANES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*QLEN-1:0] in_a,
    input  logic [LANES*QLEN-1:0] in_b,
    input  logic                  in_round,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*QLEN-1:0] out_res,
    output logic [LANES-1:0]      out_ovf,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr
);

    localparam int c_PROD_W = 2 * QLEN;
    // One extra bit so adding the rounding constant cannot wrap.
    localparam int c_EXT_W  = 2 * QLEN + 1;

    localparam logic signed [c_EXT_W-1:0] c_MAX  = {{(QLEN + 2){1'b0}}, {(QLEN - 1){1'b1}}};
    localparam logic signed [c_EXT_W-1:0] c_MIN  = {{(QLEN + 2){1'b1}}, {(QLEN - 1){1'b0}}};
    localparam logic signed [c_EXT_W-1:0] c_HALF = c_EXT_W'(1) << (FRAC_SIZE - 1);
    localparam logic [QLEN-1:0]           c_SAT_HI = {1'b0, {(QLEN - 1){1'b1}}};
    localparam logic [QLEN-1:0]           c_SAT_LO = {1'b1, {(QLEN - 1){1'b0}}};

    logic                              w_en1;
    logic                              w_en2;
    logic [LANES-1:0][c_PROD_W-1:0]    w_prod;
    logic [LANES*QLEN-1:0]             w_res;
    logic [LANES-1:0]                  w_ovf;

    logic                              r_s1_valid;
    logic                              r_s1_round;
    logic [LANES-1:0][c_PROD_W-1:0]    r_s1_prod;
    logic                              r_s2_valid;
    logic [LANES*QLEN-1:0]             r_out_res;
    logic [LANES-1:0]                  r_out_ovf;
    logic                              r_ovf_sticky;

    assign w_en2 = !r_s2_valid || out_ready;
    assign w_en1 = !r_s1_valid || w_en2;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [QLEN-1:0]    w_a;
        logic signed [QLEN-1:0]    w_b;
        logic signed [c_EXT_W-1:0] w_ext;
        logic signed [c_EXT_W-1:0] w_sum;
        logic signed [c_EXT_W-1:0] w_r;
        logic                      w_hi;
        logic                      w_lo;

        assign w_a        = in_a[gi*QLEN +: QLEN];
        assign w_b        = in_b[gi*QLEN +: QLEN];
        assign w_prod[gi] = c_PROD_W'(w_a) * c_PROD_W'(w_b);

        assign w_ext = c_EXT_W'($signed(r_s1_prod[gi]));
        assign w_sum = w_ext + (r_s1_round ? c_HALF : '0);
        assign w_r   = w_sum >>> FRAC_SIZE;
        assign w_hi  = (w_r > c_MAX);
        assign w_lo  = (w_r < c_MIN);

        assign w_res[gi*QLEN +: QLEN] = w_hi ? c_SAT_HI : (w_lo ? c_SAT_LO : w_r[QLEN-1:0]);
        assign w_ovf[gi]              = w_hi | w_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_round <= 1'b0;
            r_s1_prod  <= '0;
        end else if (w_en1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_prod  <= w_prod;
                r_s1_round <= in_round;
            end
        end
    end

    // Output registers only change when the stage is enabled, so data holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_res  <= '0;
            r_out_ovf  <= '0;
        end else if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_res <= w_res;
                r_out_ovf <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_s2_valid && out_ready && (|r_out_ovf)) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign in_ready   = w_en1;
    assign out_valid  = r_s2_valid;
    assign out_res    = r_out_res;
    assign out_ovf    = r_out_ovf;
    assign ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire
